filter_ctrl_5x5: RTL

FILTER_CTRL_5X5 -- requirements
Module: filter_ctrl_5x5

---
 rtl/filter_ctrl_5x5.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/filter_ctrl_5x5.sv
// Line-buffer controller for a 5x5 window filter: column/line counters, memory rotation,
// vertical padding flags and two end-of-frame flush lines. Optional FILTER_CTRL_5X5_ERR_EN adds o_err.
module filter_ctrl_5x5 #(
  parameter int unsigned MEM_ADDR_WIDTH = 11,
  parameter int unsigned H_ACTIVE       = 1920,
  parameter int unsigned V_ACTIVE       = 1080,
  parameter int unsigned H_BLANK        = 280
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_vsync,
  input  logic                      i_de,
  output logic                      o_mem_ren,
  output logic [1:0]                o_mem_sel,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_waddr,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_raddr,
  output logic [3:0]                o_pad_y,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int unsigned AW = MEM_ADDR_WIDTH;
  localparam int unsigned NW = $clog2(V_ACTIVE + 3);
  localparam int unsigned GW = $clog2(H_BLANK) + 1;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_ACTIVE     = 2'd1;
  localparam logic [1:0] S_FLUSH_GAP  = 2'd2;
  localparam logic [1:0] S_FLUSH_LINE = 2'd3;

  logic [1:0]    state_q, state_nx;
  logic [AW-1:0] col_q, waddr_q;
  logic [NW-1:0] line_q;
  logic [GW-1:0] gap_q;
  logic          strobe_q, pend_q, busy_q;
  logic [1:0]    sel_q;
  logic [3:0]    pad_q;

  logic          strobe_c, line_end_c, col_last_c, gap_done_c;
  logic [3:0]    pad_c;

  // Read strobe (accepted input pixel or flush read) and line-boundary decode
  always_comb begin
    strobe_c   = (state_q == S_ACTIVE && i_de) || (state_q == S_FLUSH_LINE);
    line_end_c = strobe_q && !strobe_c;
    col_last_c = (col_q == AW'(H_ACTIVE - 1));
    gap_done_c = (gap_q == GW'(H_BLANK - 1));
  end

  // Padding flags for window-centre row c = line - 2
  always_comb begin
    pad_c = 4'b0000;
    if (line_q == NW'(2))                 pad_c = 4'b0001;
    else if (line_q == NW'(3))            pad_c = 4'b0010;
    else if (line_q == NW'(V_ACTIVE))     pad_c = 4'b1000;
    else if (line_q == NW'(V_ACTIVE + 1)) pad_c = 4'b0100;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_nx;
  end

  // Next state; i_vsync restarts the frame from any state
  always_comb begin
    state_nx = state_q;
    if (i_vsync) begin
      state_nx = S_ACTIVE;
    end else begin
      case (state_q)
        S_ACTIVE:     if (line_end_c && line_q == NW'(V_ACTIVE - 1)) state_nx = S_FLUSH_GAP;
        S_FLUSH_GAP:  if (gap_done_c) state_nx = S_FLUSH_LINE;
        S_FLUSH_LINE: if (col_last_c) state_nx = (line_q == NW'(V_ACTIVE)) ? S_FLUSH_GAP : S_IDLE;
        default:      state_nx = state_q;
      endcase
    end
  end

  // Counters, rotation select and padding flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q   <= 1'b0;
      waddr_q  <= '0;
      col_q    <= '0;
      strobe_q <= 1'b0;
      line_q   <= '0;
      pend_q   <= 1'b0;
      gap_q    <= '0;
      sel_q    <= 2'b00;
      pad_q    <= 4'b0000;
    end else begin
      busy_q  <= (state_nx != S_IDLE);
      waddr_q <= col_q;
      if (i_vsync) begin
        col_q    <= '0;
        strobe_q <= 1'b0;
        line_q   <= '0;
        pend_q   <= 1'b0;
        gap_q    <= '0;
        sel_q    <= 2'b00;
        pad_q    <= 4'b0000;
      end else begin
        strobe_q <= strobe_c;
        if (!strobe_c)       col_q <= '0;
        else if (!col_last_c) col_q <= col_q + AW'(1);
        // The cycle after the last ACTIVE pixel already counts as the first gap cycle
        if (state_q == S_FLUSH_GAP)   gap_q <= gap_q + GW'(1);
        else if (state_q == S_ACTIVE) gap_q <= GW'(1);
        else                          gap_q <= '0;
        if (line_end_c) line_q <= line_q + NW'(1);
        pend_q <= line_end_c;
        // Select/flags land three clocks after the line's last strobe cycle
        if (pend_q) begin
          sel_q <= line_q[1:0];
          pad_q <= pad_c;
        end
      end
    end
  end

  assign o_mem_ren   = (state_q == S_ACTIVE && i_de && line_q >= NW'(2)) || (state_q == S_FLUSH_LINE);
  assign o_mem_raddr = col_q;
  assign o_mem_waddr = waddr_q;
  assign o_mem_sel   = sel_q;
  assign o_pad_y     = pad_q;
  assign o_busy      = busy_q;

`ifdef FILTER_CTRL_5X5_ERR_EN
  logic de_q, err_q;

  // One pulse per ignored i_de run, or per i_vsync arriving mid-frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      de_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      de_q  <= i_de;
      err_q <= (i_de && !de_q && state_q != S_ACTIVE) || (i_vsync && state_q == S_ACTIVE);
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule
